// File: rtl/rv_iopmp_entry_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_iopmp_entry_port_arbiter
// Purpose  : Shares the single read port of the IOPMP entry RAM among several
//            matching-logic instances. Grants are round-robin. An instance
//            keeps the port for a whole run of reads until it marks one as
//            last. Read responses are routed back to the requester through a
//            tag pipeline that is as deep as the RAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module rv_iopmp_entry_port_arbiter #(
    parameter  int NUMBER_TL_INSTANCES = 2,
    parameter  int NUMBER_ENTRIES      = 8,
    parameter  int ENTRY_WIDTH         = 128,
    parameter  int RAM_LATENCY         = 1,
    localparam int AW = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              stall_i,
    input  logic [NUMBER_TL_INSTANCES-1:0]    req_valid_i,
    input  logic [NUMBER_TL_INSTANCES-1:0]    req_last_i,
    input  logic [NUMBER_TL_INSTANCES*AW-1:0] req_addr_i,
    output logic [NUMBER_TL_INSTANCES-1:0]    req_ready_o,
    output logic [NUMBER_TL_INSTANCES-1:0]    rsp_valid_o,
    output logic [ENTRY_WIDTH-1:0]            rsp_data_o,
    output logic                              ram_en_o,
    output logic [AW-1:0]                     ram_addr_o,
    input  logic [ENTRY_WIDTH-1:0]            ram_rdata_i
);

    localparam int N  = NUMBER_TL_INSTANCES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e        state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_q;
    logic [N-1:0]  tag_q [RAM_LATENCY];

    logic [2*N-1:0] cand_dbl;
    logic [N-1:0]   cand_rot;
    logic [IW-1:0]  cand_off;
    logic [IW:0]    cand_sum;
    logic [IW-1:0]  cand_idx;
    logic           cand_found;

    logic [IW-1:0]  sel_idx;
    logic           sel_valid;
    logic           sel_last;
    logic           grant_en;
    logic [N-1:0]   grant;
    logic [AW-1:0]  sel_addr;

    // Wrap-around increment of an instance index.
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] x);
        return (x == IW'(N - 1)) ? '0 : x + IW'(1);
    endfunction

    // Round-robin search: rotate the request vector so rr_q sits at bit 0,
    // take the first set bit, then rotate the offset back to an index.
    always_comb begin
        cand_dbl   = {req_valid_i, req_valid_i};
        cand_rot   = cand_dbl[rr_q +: N];
        cand_off   = '0;
        cand_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!cand_found && cand_rot[k]) begin
                cand_found = 1'b1;
                cand_off   = IW'(k);
            end
        end
        cand_sum = {1'b0, rr_q} + {1'b0, cand_off};
        if (cand_sum >= (IW + 1)'(N)) begin
            cand_sum = cand_sum - (IW + 1)'(N);
        end
        cand_idx = cand_sum[IW-1:0];
    end

    // Grant selection: the locked owner only, otherwise the round-robin
    // candidate. Reset and stall both suppress the grant combinationally.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            sel_idx   = owner_q;
            sel_valid = req_valid_i[owner_q];
        end else begin
            sel_idx   = cand_idx;
            sel_valid = cand_found;
        end
        sel_last = req_last_i[sel_idx];
        grant_en = sel_valid & ~stall_i & ~rst_i;
        grant    = grant_en ? (N'(1) << sel_idx) : '0;
        sel_addr = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_idx == IW'(k)) begin
                sel_addr = req_addr_i[k*AW +: AW];
            end
        end
    end

    // RAM issue and response routing. The response is hidden while reset is
    // asserted, so reads that were in flight at reset never reach a requester.
    always_comb begin
        req_ready_o = grant;
        ram_en_o    = grant_en;
        ram_addr_o  = grant_en ? sel_addr : '0;
        rsp_valid_o = rst_i ? '0 : tag_q[RAM_LATENCY-1];
        rsp_data_o  = (|rsp_valid_o) ? ram_rdata_i : '0;
    end

    // Lock FSM, round-robin pointer and the grant tag pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            for (int s = 0; s < RAM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= grant;
            for (int s = 1; s < RAM_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_en) begin
                        owner_q <= sel_idx;
                        if (sel_last) begin
                            rr_q <= f_next(sel_idx);
                        end else begin
                            state_q <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (grant_en && sel_last) begin
                        state_q <= ST_IDLE;
                        rr_q    <= f_next(owner_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_iopmp_entry_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_iopmp_entry_port_arbiter
// Purpose  : Directed self-checking bench for the entry RAM port arbiter.
//            One instance uses a 1-cycle RAM, one uses a 3-cycle RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_iopmp_entry_port_arbiter;

    logic         clk;
    logic         rst;
    logic         stall;
    logic [1:0]   v, l, ready, rsp;
    logic [5:0]   a;
    logic [127:0] data, rdata;
    logic         en;
    logic [2:0]   addr;

    logic [1:0]   v3, l3, ready3, rsp3;
    logic [5:0]   a3;
    logic [127:0] data3, rdata3;
    logic         en3;
    logic [2:0]   addr3;

    logic [127:0] p1, p2, p3;

    int total;
    int bad;

    // Contents of RAM word n: distinct 16-bit pattern repeated.
    function automatic logic [127:0] word(input logic [2:0] n);
        return {8{13'h1A5C, n}};
    endfunction

    rv_iopmp_entry_port_arbiter #(
        .NUMBER_TL_INSTANCES(2), .NUMBER_ENTRIES(8), .ENTRY_WIDTH(128), .RAM_LATENCY(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .req_valid_i(v), .req_last_i(l), .req_addr_i(a),
        .req_ready_o(ready), .rsp_valid_o(rsp), .rsp_data_o(data),
        .ram_en_o(en), .ram_addr_o(addr), .ram_rdata_i(rdata)
    );

    rv_iopmp_entry_port_arbiter #(
        .NUMBER_TL_INSTANCES(2), .NUMBER_ENTRIES(8), .ENTRY_WIDTH(128), .RAM_LATENCY(3)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .req_valid_i(v3), .req_last_i(l3), .req_addr_i(a3),
        .req_ready_o(ready3), .rsp_valid_o(rsp3), .rsp_data_o(data3),
        .ram_en_o(en3), .ram_addr_o(addr3), .ram_rdata_i(rdata3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1-cycle RAM model.
    always @(posedge clk) begin
        if (en) rdata <= word(addr);
    end

    // 3-cycle RAM model.
    always @(posedge clk) begin
        if (en3) p1 <= word(addr3);
        p2 <= p1;
        p3 <= p2;
    end
    assign rdata3 = p3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; stall = 1'b0;
        v = '0; l = '0; a = '0;
        v3 = '0; l3 = '0; a3 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        v = 2'b11; l = 2'b11; a = {3'd5, 3'd3};
        v3 = 2'b11; l3 = 2'b11; a3 = {3'd5, 3'd3};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (ready !== 2'b00 || rsp !== 2'b00) begin
                bad++; $display("FAIL reset_hs[%0d] ready=%b rsp=%b want 00/00", k, ready, rsp);
            end
            total++;
            if (en !== 1'b0 || addr !== 3'd0 || data !== 128'd0) begin
                bad++; $display("FAIL reset_ram[%0d] en=%b addr=%0d data=%h want 0", k, en, addr, data);
            end
            total++;
            if (ready3 !== 2'b00 || en3 !== 1'b0) begin
                bad++; $display("FAIL reset_lat3[%0d] ready=%b en=%b want 00/0", k, ready3, en3);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 2'b01 || addr !== 3'd3) begin
            bad++; $display("FAIL reset_first_grant ready=%b addr=%0d want 01/3", ready, addr);
        end
        step();
        v = '0; v3 = '0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] er, ers;
        logic [2:0] ea;
        apply_reset();
        v = 2'b11; l = 2'b11; a = {3'd5, 3'd3};
        for (int k = 0; k < 4; k++) begin
            er  = (k % 2 == 1) ? 2'b10 : 2'b01;
            ea  = (k % 2 == 1) ? 3'd5 : 3'd3;
            ers = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            @(negedge clk);
            total++;
            if (ready !== er || addr !== ea || en !== 1'b1) begin
                bad++; $display("FAIL rr_grant[%0d] ready=%b addr=%0d en=%b want %b/%0d/1", k, ready, addr, en, er, ea);
            end
            total++;
            if (rsp !== ers) begin
                bad++; $display("FAIL rr_rsp[%0d] rsp=%b want %b", k, rsp, ers);
            end
            if (k > 0) begin
                total++;
                if (data !== word((k % 2 == 1) ? 3'd3 : 3'd5)) begin
                    bad++; $display("FAIL rr_data[%0d] got=%h", k, data);
                end
            end
            step();
        end
        v = '0;
        @(negedge clk);
        total++;
        if (rsp !== 2'b10 || data !== word(3'd5) || en !== 1'b0) begin
            bad++; $display("FAIL rr_tail rsp=%b en=%b data=%h want 10/0/word5", rsp, en, data);
        end
        step();
    endtask

    task automatic test_lock();
        logic       v0_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] a0_t [6] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3};
        logic [1:0] er_t [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        logic [1:0] prev_r;
        logic [2:0] prev_a;
        apply_reset();
        v[1] = 1'b1; l[1] = 1'b1; a[5:3] = 3'd6;
        prev_r = 2'b00; prev_a = 3'd0;
        for (int k = 0; k < 6; k++) begin
            v[0] = v0_t[k]; a[2:0] = a0_t[k]; l[0] = (k == 5);
            @(negedge clk);
            total++;
            if (ready !== er_t[k]) begin
                bad++; $display("FAIL lock_ready[%0d] got=%b want=%b", k, ready, er_t[k]);
            end
            total++;
            if (rsp !== prev_r) begin
                bad++; $display("FAIL lock_rsp[%0d] got=%b want=%b", k, rsp, prev_r);
            end
            if (prev_r != 2'b00) begin
                total++;
                if (data !== word(prev_a)) begin
                    bad++; $display("FAIL lock_data[%0d] got=%h want=%h", k, data, word(prev_a));
                end
            end
            prev_r = er_t[k]; prev_a = a0_t[k];
            step();
        end
        v[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 2'b10 || addr !== 3'd6) begin
            bad++; $display("FAIL lock_handover ready=%b addr=%0d want 10/6", ready, addr);
        end
        step();
        v = '0;
        @(negedge clk);
        total++;
        if (rsp !== 2'b10 || data !== word(3'd6)) begin
            bad++; $display("FAIL lock_rsp1 rsp=%b data=%h want 10/word6", rsp, data);
        end
        step();
    endtask

    task automatic test_stall();
        apply_reset();
        v = 2'b01; l = 2'b01; a[2:0] = 3'd4;
        @(negedge clk);
        total++;
        if (ready !== 2'b01) begin
            bad++; $display("FAIL stall_pre ready=%b want 01", ready);
        end
        step();
        v = 2'b11; l = 2'b01; a[5:3] = 3'd1;
        @(negedge clk);
        total++;
        if (ready !== 2'b10 || addr !== 3'd1) begin
            bad++; $display("FAIL stall_lock ready=%b addr=%0d want 10/1", ready, addr);
        end
        step();
        a[5:3] = 3'd2; l[1] = 1'b1; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (ready !== 2'b00 || en !== 1'b0) begin
                bad++; $display("FAIL stall_block[%0d] ready=%b en=%b want 00/0", k, ready, en);
            end
            total++;
            if (rsp !== ((k == 0) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL stall_rsp[%0d] rsp=%b", k, rsp);
            end
            if (k == 0) begin
                total++;
                if (data !== word(3'd1)) begin
                    bad++; $display("FAIL stall_inflight got=%h want=%h", data, word(3'd1));
                end
            end
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 2'b10 || addr !== 3'd2) begin
            bad++; $display("FAIL stall_resume ready=%b addr=%0d want 10/2", ready, addr);
        end
        step();
        v[1] = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 2'b01 || addr !== 3'd4 || rsp !== 2'b10 || data !== word(3'd2)) begin
            bad++; $display("FAIL stall_after ready=%b addr=%0d rsp=%b want 01/4/10", ready, addr, rsp);
        end
        step();
        v = '0;
        step();
    endtask

    task automatic test_latency();
        logic [1:0] ers;
        apply_reset();
        v3 = 2'b01; l3 = 2'b01; a3[2:0] = 3'd7;
        @(negedge clk);
        total++;
        if (en3 !== 1'b1 || addr3 !== 3'd7 || ready3 !== 2'b01) begin
            bad++; $display("FAIL lat_issue en=%b addr=%0d ready=%b want 1/7/01", en3, addr3, ready3);
        end
        step();
        v3 = '0;
        for (int c = 1; c < 5; c++) begin
            ers = (c == 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            total++;
            if (rsp3 !== ers || data3 !== ((c == 3) ? word(3'd7) : 128'd0)) begin
                bad++; $display("FAIL lat_rsp[%0d] rsp=%b want=%b data=%h", c, rsp3, ers, data3);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ers;
        logic [127:0] ed;
        apply_reset();
        v3 = 2'b11; l3 = 2'b11; a3 = {3'd5, 3'd2};
        @(negedge clk);
        total++;
        if (ready3 !== 2'b01 || addr3 !== 3'd2) begin
            bad++; $display("FAIL b2b_g0 ready=%b addr=%0d want 01/2", ready3, addr3);
        end
        step();
        @(negedge clk);
        total++;
        if (ready3 !== 2'b10 || addr3 !== 3'd5) begin
            bad++; $display("FAIL b2b_g1 ready=%b addr=%0d want 10/5", ready3, addr3);
        end
        step();
        v3 = '0;
        for (int c = 2; c < 6; c++) begin
            ers = (c == 3) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
            ed  = (c == 3) ? word(3'd2) : ((c == 4) ? word(3'd5) : 128'd0);
            @(negedge clk);
            total++;
            if (rsp3 !== ers || data3 !== ed) begin
                bad++; $display("FAIL b2b_rsp[%0d] rsp=%b want=%b data=%h want=%h", c, rsp3, ers, data3, ed);
            end
            step();
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        v = 2'b01; l = 2'b00; a[2:0] = 3'd4;
        @(negedge clk);
        total++;
        if (ready !== 2'b01) begin
            bad++; $display("FAIL midrst_grant ready=%b want 01", ready);
        end
        step();
        rst = 1'b1; a[2:0] = 3'd5; l = 2'b01;
        @(negedge clk);
        total++;
        if (rsp !== 2'b00 || ready !== 2'b00) begin
            bad++; $display("FAIL midrst_during rsp=%b ready=%b want 00/00", rsp, ready);
        end
        step();
        rst = 1'b0; v = 2'b10; l = 2'b10; a[5:3] = 3'd6;
        @(negedge clk);
        total++;
        if (rsp !== 2'b00) begin
            bad++; $display("FAIL midrst_dropped rsp=%b want 00", rsp);
        end
        total++;
        if (ready !== 2'b10 || addr !== 3'd6) begin
            bad++; $display("FAIL midrst_idle ready=%b addr=%0d want 10/6", ready, addr);
        end
        step();
        v = '0;
        @(negedge clk);
        total++;
        if (rsp !== 2'b10 || data !== word(3'd6)) begin
            bad++; $display("FAIL midrst_next rsp=%b data=%h want 10/word6", rsp, data);
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_round_robin();
        test_lock();
        test_stall();
        test_latency();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
